// File: rtl/rr_channel_arbiter_pkg.sv
// rtl/rr_channel_arbiter_pkg.sv - shared sizes, state type and pointer wrap helper for the channel arbiter
package rr_channel_arbiter_pkg;
    localparam int N_CH   = 32;
    localparam int SEL_W  = 5;
    localparam int DATA_W = 20;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] cur);
        ptr_next = (cur == SEL_W'(N_CH - 1)) ? '0 : cur + 1'b1;
    endfunction
endpackage

// File: rtl/rr_channel_arbiter_pick.sv
// rtl/rr_channel_arbiter_pick.sv - combinational round-robin picker (rotate, priority-encode, un-rotate)
module rr_pick
    import rr_channel_arbiter_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [N_CH-1:0]  rot;
    logic [SEL_W-1:0] off;

    // Bit 0 of rot is channel ptr, so the lowest set bit is the next in turn.
    assign rot = N_CH'({req, req} >> ptr);

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = SEL_W'(i);
            end
        end
    end

    assign idx = off + ptr;
endmodule

// File: rtl/rr_channel_arbiter.sv
// rtl/rr_channel_arbiter.sv - round-robin channel arbiter forwarding bounded bursts to one downstream port
module rr_channel_arbiter
    import rr_channel_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_last,
    output logic [N_CH-1:0]          in_ready,
    output logic [SEL_W-1:0]         sel,
    output logic [N_CH-1:0]          grant,
    output logic                     busy,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    input  logic                     out_ready
);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             xfer;
    logic [N_CH-1:0]  sel_onehot;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_onehot = N_CH'(1) << sel_q;
    assign sel        = sel_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        grant     = '0;
        in_ready  = '0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = BURST;
                end
            end
            BURST: begin
                busy      = 1'b1;
                grant     = sel_onehot;
                out_valid = req[sel_q];
                out_data  = in_data[sel_q*DATA_W +: DATA_W];
                out_last  = in_last[sel_q] | (cnt_q == CNT_W'(MAX_BURST - 1));
                in_ready  = out_ready ? sel_onehot : '0;
                xfer      = out_valid & out_ready;
                // sel is kept after release so the datapath select stays stable while idle.
                if (xfer) begin
                    if (out_last) begin
                        state_d = IDLE;
                        ptr_d   = ptr_next(sel_q);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rr_channel_arbiter.sv
// tb/tb_rr_channel_arbiter.sv - self-checking bench for rr_channel_arbiter
module tb_rr_channel_arbiter;
    import rr_channel_arbiter_pkg::*;
    localparam int MB = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH-1:0]        req, in_last, in_ready, grant;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [SEL_W-1:0]       sel;
    logic                   busy, out_valid, out_last, out_ready;
    logic [DATA_W-1:0]      out_data;

    always #5 clk = ~clk;

    rr_channel_arbiter #(.MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .sel(sel), .grant(grant), .busy(busy),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: who holds the grant, whose turn is next, beats already sent.
    bit m_busy;
    int m_sel, m_ptr, m_beats;
    bit hold_pending;
    int hold_ch;

    typedef struct {
        logic [N_CH-1:0]  req;
        logic [N_CH-1:0]  last;
        logic             ordy;
        logic [N_CH-1:0]  g;
        logic [SEL_W-1:0] s;
        logic             v;
        logic             l;
        logic [N_CH-1:0]  ir;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] chan_data(input int c);
        return in_data[c*DATA_W +: DATA_W];
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_ptr = 0; m_sel = 0; m_beats = 0; hold_pending = 1'b0;
    endtask

    task automatic sample();
        logic [N_CH-1:0] g;
        @(negedge clk);
        g = '0;
        if (m_busy) g[m_sel] = 1'b1;
        chk("grant", 64'(grant), 64'(g));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("sel", 64'(sel), 64'(m_sel));
        chk("out_valid", 64'(out_valid), 64'(m_busy && req[m_sel]));
        chk("out_data", 64'(out_data), m_busy ? 64'(chan_data(m_sel)) : 64'(0));
        chk("out_last", 64'(out_last), 64'(m_busy && (in_last[m_sel] || m_beats == MB - 1)));
        chk("in_ready", 64'(in_ready), (m_busy && out_ready) ? 64'(g) : 64'(0));
        if (hold_pending) chk("req_held_under_stall", 64'(req[hold_ch]), 64'(1));
    endtask

    task automatic adv();
        @(posedge clk);
        hold_pending = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < N_CH; k++) begin
                int c;
                c = (m_ptr + k) % N_CH;
                if (req[c]) begin
                    m_busy = 1'b1; m_sel = c; m_beats = 0;
                    break;
                end
            end
        end else if (req[m_sel] && out_ready) begin
            m_beats++;
            if (in_last[m_sel] || m_beats == MB) begin
                m_busy = 1'b0; m_ptr = (m_sel + 1) % N_CH; m_beats = 0;
            end
        end else if (req[m_sel]) begin
            hold_pending = 1'b1; hold_ch = m_sel;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; in_last = '0; out_ready = 1'b0; in_data = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N_CH; i++) in_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    initial begin
        logic [N_CH-1:0] exp_g[8];
        int xfers;

        do_reset();

        // Single requester, pointer advance and wrap through the table.
        tbl[0] = '{32'h20, 32'h0,  1'b1, 32'h0,  5'd0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{32'h20, 32'h0,  1'b1, 32'h20, 5'd5, 1'b1, 1'b0, 32'h20};
        tbl[2] = '{32'h20, 32'h20, 1'b1, 32'h20, 5'd5, 1'b1, 1'b1, 32'h20};
        tbl[3] = '{32'h60, 32'h0,  1'b1, 32'h0,  5'd5, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{32'h60, 32'h0,  1'b1, 32'h40, 5'd6, 1'b1, 1'b0, 32'h40};
        tbl[5] = '{32'h60, 32'h40, 1'b1, 32'h40, 5'd6, 1'b1, 1'b1, 32'h40};
        tbl[6] = '{32'h60, 32'h0,  1'b1, 32'h0,  5'd6, 1'b0, 1'b0, 32'h0};
        tbl[7] = '{32'h60, 32'h0,  1'b1, 32'h20, 5'd5, 1'b1, 1'b0, 32'h20};
        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req; in_last = tbl[i].last; out_ready = tbl[i].ordy;
            rand_data();
            sample();
            chk($sformatf("tbl%0d_grant", i), 64'(grant), 64'(tbl[i].g));
            chk($sformatf("tbl%0d_sel", i), 64'(sel), 64'(tbl[i].s));
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].v));
            chk($sformatf("tbl%0d_last", i), 64'(out_last), 64'(tbl[i].l));
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
            adv();
        end

        // Round-robin order across the 31->0 wrap.
        do_reset();
        in_last = '1; out_ready = 1'b1; req = 32'h1 << 29;
        sample(); adv();
        sample(); chk("wrap_prime_grant", 64'(grant), 64'(32'h1 << 29)); adv();
        req = 32'hC000_0001;
        exp_g = '{32'h0, 32'h4000_0000, 32'h0, 32'h8000_0000, 32'h0, 32'h1, 32'h0, 32'h4000_0000};
        for (int i = 0; i < 8; i++) begin
            sample(); chk($sformatf("wrap_grant%0d", i), 64'(grant), 64'(exp_g[i])); adv();
        end

        // Forced release after MAX_BURST beats, then the neighbour gets its turn.
        do_reset();
        req = (32'h1 << 7) | (32'h1 << 8); out_ready = 1'b1;
        sample(); adv();
        for (int i = 0; i < MB; i++) begin
            rand_data();
            sample();
            chk($sformatf("force_grant%0d", i), 64'(grant), 64'(32'h1 << 7));
            chk($sformatf("force_last%0d", i), 64'(out_last), 64'(i == MB - 1));
            adv();
        end
        sample(); chk("force_bubble", 64'(grant), 64'(0)); adv();
        sample(); chk("force_next", 64'(grant), 64'(32'h1 << 8)); adv();

        // Backpressure on channel 12: nothing lost, nothing repeated.
        do_reset();
        req = 32'h1 << 12; out_ready = 1'b1; xfers = 0;
        sample(); adv();
        for (int i = 0; i < 8; i++) begin
            out_ready = !(i >= 1 && i <= 3);
            rand_data();
            sample();
            if (!out_ready) begin
                chk("bp_in_ready", 64'(in_ready), 64'(0));
                chk("bp_out_data", 64'(out_data), 64'(in_data[12*DATA_W +: DATA_W]));
                chk("bp_out_last", 64'(out_last), 64'(0));
            end
            if (out_valid && out_ready) xfers++;
            adv();
        end
        chk("bp_beat_count", 64'(xfers), 64'(MB));

        // Asynchronous reset in the middle of beat 2.
        do_reset();
        req = 32'h8; out_ready = 1'b1;
        sample(); adv();
        sample(); adv();
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 64'(grant), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_valid", 64'(out_valid), 64'(0));
        model_reset();
        sample();
        @(posedge clk); #1;
        rst_n = 1'b1; req = 32'h0010_0008;
        sample(); adv();
        sample(); chk("arst_regrant", 64'(grant), 64'(32'h8)); adv();

        // Requester gap on channel 9 holds the grant.
        do_reset();
        req = 32'h1 << 9; out_ready = 1'b1;
        sample(); adv();
        sample(); adv();
        req = (32'h1 << 10) | 32'h4;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("gap_grant", 64'(grant), 64'(32'h1 << 9));
            chk("gap_valid", 64'(out_valid), 64'(0));
            adv();
        end
        req = (32'h1 << 9) | (32'h1 << 10);
        for (int i = 0; i < 6; i++) begin sample(); adv(); end

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            req = ($urandom_range(0, 7) == 0) ? '0 : ($urandom & $urandom & $urandom);
            if (hold_pending) req[hold_ch] = 1'b1;
            in_last = $urandom & $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            sample(); adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_channel_arbiter.md
Name: rr_channel_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 32-channel × 20-bit select datapath.
- Accepts requests from 32 producers and grants exactly one at a time.
- Drives the 5-bit channel select and the one-hot grant.
- Forwards the granted channel's data beats to a single downstream valid/ready port, with a bounded burst length per grant.

Parameters:
- N_CH, 32, number of requesting channels.
- SEL_W, 5, select/index width; must equal log2(N_CH).
- DATA_W, 20, beat width per channel.
- MAX_BURST, 4, maximum beats per grant before forced release; legal range 1..16.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_CH  per-channel request; also acts as that channel's beat-valid.
- in_data  in  N_CH*DATA_W  flattened channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_last  in  N_CH  per-channel last-beat flag.
- in_ready  out  N_CH  one-hot beat-accept to the granted channel.
- sel  out  SEL_W  index of the current or most recent grant; feeds the datapath select.
- grant  out  N_CH  one-hot grant; all zero when idle.
- busy  out  1  high while in BURST.
- out_valid  out  1  downstream beat valid.
- out_data  out  DATA_W  downstream beat data.
- out_last  out  1  downstream last beat; true or forced.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE, ptr=0, sel=0, grant=0, busy=0, beat_cnt=0. Combinational outputs evaluate to 0.
- Reset mid-burst aborts immediately. The partial burst is not completed and no beat is counted.
- States:
  - IDLE: grant=0, in_ready=0, out_valid=0.
  - BURST: grant=1<<sel.
- IDLE→BURST: on any req bit set, pick the first requesting index searching ptr, ptr+1, …, N_CH-1, 0, …, ptr-1 (mod N_CH). Register it into sel and enter BURST next cycle. Latency is 1 cycle from req to grant.
- BURST outputs (combinational from registered sel):
  - out_valid = req[sel].
  - out_data = in_data[sel].
  - in_ready = out_ready ? (1<<sel) : 0.
  - out_last = in_last[sel] | (beat_cnt == MAX_BURST-1).
- Transfer occurs when out_valid & out_ready; beat_cnt increments on each transfer.
- Release: on a transfer with out_last=1, go to IDLE and set ptr=(sel+1) mod N_CH with wrap 31→0. Clear beat_cnt. sel holds its value.
- After release there is one IDLE bubble cycle before the next grant. Back-to-back grants never occur in the same cycle.
- No preemption:
  - If req[sel] drops mid-burst, the grant holds and out_valid=0 until req returns or reset.
  - A requester must not drop req while holding a beat with out_ready low. A bench assertion checks this.
- Stall: while out_ready=0 all state holds and out_data tracks in_data[sel].
- Non-granted channels always see in_ready=0, regardless of their req.
- beat_cnt width is clog2(MAX_BURST)+1. It never exceeds MAX_BURST-1.
- MAX_BURST=1 means every beat is last, giving a pure per-beat round robin.

Decomposition:
- Shared package holds N_CH, SEL_W, DATA_W, the state typedef (IDLE, BURST) and the ptr_next wrap helper function.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req[N_CH], ptr[SEL_W].
  - Outputs: idx[SEL_W], found.
  - Implementation: rotate, priority-encode, un-rotate.
- Grant one-hot is decoded from sel inside the top level.

Test Plan:
- Single requester:
  - Stimulus: after reset, req=1<<5, in_last[5] high on beat 2, out_ready=1.
  - Response: grant=0x00000020 at cycle 1, sel=5, two transfers, then IDLE and ptr=6.
- Round-robin order with wrap:
  - Stimulus: ptr forced to 30 via a prior grant of channel 29, req=0xC0000001 held.
  - Response: grant order 30, 31, 0, 30, each separated by one idle cycle.
- Forced release:
  - Stimulus: MAX_BURST=4, channel 7 streams with in_last=0, out_ready=1.
  - Response: out_last=1 on beat 4, grant drops, and with channel 8 also requesting, the next grant is channel 8.
- Backpressure:
  - Stimulus: mid-burst on channel 12, out_ready=0 for 3 cycles.
  - Response: in_ready=0 for those cycles, beat_cnt unchanged, out_data=in_data[12], no beat lost or duplicated.
- Async reset mid-burst:
  - Stimulus: rst_n low during beat 2 of channel 3.
  - Response: grant=0, busy=0, out_valid=0 in the same cycle. After release, the first grant for req=0x8 is channel 3, since ptr=0 searches 0,1,2,3.
- Requester gap:
  - Stimulus: req[9] drops for 2 cycles mid-burst.
  - Response: grant stays 1<<9, out_valid=0, and other requesters are not granted.
